// File: rtl/iir_out_quant.sv
`default_nettype none
// ============================================================================
// Module   : iir_out_quant
// Function : Rounds and saturates the SOS cascade result, then buffers it in
//            a small FIFO with a valid/ready output handshake.
// Option   : IIR_OUT_CONVERGENT_ROUND_EN selects round-half-to-even.
// Revision : 1.0
// ============================================================================

module iir_out_quant #(
  parameter int WII   = 23,
  parameter int WFI   = 44,
  parameter int WIQ   = 5,
  parameter int WFQ   = 11,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WII+WFI-1:0]         din,
  input  logic                       in_valid,
  output logic [WIQ+WFQ-1:0]         out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       clr_flags,
  output logic                       ovf_sticky,
  output logic                       drop_sticky,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int W_IN  = WII + WFI;
  localparam int W_EXT = W_IN + 1;
  localparam int D     = WFI - WFQ;
  localparam int W_RND = WII + 1 + WFQ;
  localparam int W_OUT = WIQ + WFQ;
  localparam int W_TOP = W_RND - W_OUT + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  localparam logic [W_EXT-1:0] C_HALF = {{(W_EXT-1){1'b0}}, 1'b1} << (D - 1);
  localparam logic [W_OUT-1:0] C_MAX  = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic [W_OUT-1:0] C_MIN  = {1'b1, {(W_OUT-1){1'b0}}};

  if (WFI <= WFQ || WII < WIQ) begin : g_bad_widths
    $error("iir_out_quant: requires WFI > WFQ and WII >= WIQ");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("iir_out_quant: DEPTH must be a power of 2 and >= 2");
  end

  // Pipeline, FIFO and flag state
  logic [W_RND-1:0] s1_data_q, s1_data_d;
  logic             s1_valid_q;
  logic [W_OUT-1:0] s2_data_q, s2_data_d;
  logic             s2_valid_q;
  logic [W_OUT-1:0] mem_q [DEPTH];
  logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [W_OUT-1:0] out_data_q, out_data_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;

  logic [W_EXT-1:0] din_ext;
  logic [W_TOP-1:0] top;
  logic             in_range;
  logic [LW-1:0]    level_w;
  logic [LW-1:0]    cnt_d;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop_evt;

  // Stage 1: sign-extend by one bit so adding the half-LSB can never wrap
  always_comb begin
    din_ext   = {din[W_IN-1], din};
    s1_data_d = W_RND'((din_ext + C_HALF) >> D);
`ifdef IIR_OUT_CONVERGENT_ROUND_EN
    if ((din[D-1:0] == C_HALF[D-1:0]) && !din[D]) begin
      s1_data_d = W_RND'(din_ext >> D);
    end
`endif
  end

  // Stage 2: value fits when all bits above the output sign agree with it
  always_comb begin
    top       = s1_data_q[W_RND-1:W_OUT-1];
    in_range  = (&top) | ~(|top);
    s2_data_d = s1_data_q[W_OUT-1:0];
    if (!in_range) begin
      s2_data_d = s1_data_q[W_RND-1] ? C_MIN : C_MAX;
    end
  end

  // FIFO control: a full FIFO still accepts a write when a pop frees a slot
  always_comb begin
    level_w  = wr_ptr_q - rd_ptr_q;
    full     = (level_w == LW'(DEPTH));
    pop      = out_valid & out_ready;
    wr_en    = s2_valid_q & (~full | pop);
    drop_evt = s2_valid_q & full & ~pop;
    wr_ptr_d = wr_ptr_q + LW'(wr_en);
    rd_ptr_d = rd_ptr_q + LW'(pop);
    cnt_d    = wr_ptr_d - rd_ptr_d;

    out_data_d = out_data_q;
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      out_data_d = s2_data_q;
    end else if (cnt_d != '0) begin
      out_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end

    ovf_d  = (ovf_q & ~clr_flags) | (s1_valid_q & ~in_range);
    drop_d = (drop_q & ~clr_flags) | drop_evt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      if (in_valid) begin
        s1_data_q <= s1_data_d;
      end
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s2_data_q;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = (level_w != '0);
  assign level       = level_w;
  assign ovf_sticky  = ovf_q;
  assign drop_sticky = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_iir_out_quant.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_out_quant
// Function : Self-checking bench for iir_out_quant (directed table, corner
//            sequences and a randomized scoreboard run).
// Revision : 1.0
// ============================================================================

module tb_iir_out_quant;

  localparam int DEPTH = 4;

  logic               CLK = 1'b0;
  logic               RST;
  logic signed [66:0] din;
  logic               in_valid;
  logic [15:0]        out_data;
  logic               out_valid;
  logic               out_ready;
  logic               clr_flags;
  logic               ovf_sticky;
  logic               drop_sticky;
  logic [2:0]         level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  iir_out_quant #(
    .WII(23), .WFI(44), .WIQ(5), .WFQ(11), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .din(din), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clr_flags(clr_flags), .ovf_sticky(ovf_sticky),
    .drop_sticky(drop_sticky), .level(level)
  );

  typedef struct {
    logic signed [66:0] din;
    logic [15:0]        exp_out;
    bit                 exp_ovf;
  } vec_t;

`ifdef IIR_OUT_CONVERGENT_ROUND_EN
  localparam logic [15:0] E_P25 = 16'h0002;
  localparam logic [15:0] E_M15 = 16'hFFFE;
`else
  localparam logic [15:0] E_P25 = 16'h0003;
  localparam logic [15:0] E_M15 = 16'hFFFF;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // din expressed in half-output-LSB units (one output LSB = 2^33 input LSBs)
  function automatic logic signed [66:0] halves(input longint k);
    logic signed [66:0] t;
    t = k;
    return t <<< 32;
  endfunction

  // Reference: floor division, tie rule, then clamp to the 16-bit range
  function automatic logic [15:0] model_q(input logic signed [66:0] d, output bit sat);
    logic signed [127:0] x, fl, rem, q, lsb, half;
    lsb  = 128'sd1 <<< 33;
    half = 128'sd1 <<< 32;
    x    = d;
    fl   = x >>> 33;
    rem  = x - fl * lsb;
    if (rem > half) q = fl + 1;
`ifdef IIR_OUT_CONVERGENT_ROUND_EN
    else if (rem == half) q = fl[0] ? fl + 1 : fl;
`else
    else if (rem == half) q = fl + 1;
`endif
    else q = fl;
    sat = 1'b1;
    if (q > 128'sd32767) return 16'h7FFF;
    if (q < -128'sd32768) return 16'h8000;
    sat = 1'b0;
    return q[15:0];
  endfunction

  function automatic logic signed [66:0] rand_din();
    logic [95:0]        r;
    logic signed [66:0] d;
    longint             k;
    r = {$urandom, $urandom, $urandom};
    k = longint'($urandom_range(0, 140000)) - 70000;
    case ($urandom_range(0, 3))
      0: d = r[66:0];
      1: d = halves(k) + $signed({35'd0, r[31:0]});
      2: d = halves(k);
      default: d = $signed(r[66:0]) >>> $urandom_range(20, 50);
    endcase
    return d;
  endfunction

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  task automatic flush();
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    pulse_clr();
    din      = v.din;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk($sformatf("vec%0d_latency", idx), 64'(n), 64'd3);
    chk($sformatf("vec%0d_data", idx), 64'(out_data), 64'(v.exp_out));
    chk($sformatf("vec%0d_ovf", idx), 64'(ovf_sticky), 64'(v.exp_ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            vt[14];
    logic            ov[7];
    logic [15:0]     q[$];
    logic signed [66:0] d;
    bit              s, any_sat;
    int              stale, guard;

    vt[0]  = '{halves(3),       16'h0002, 1'b0};
    vt[1]  = '{halves(5),       E_P25,    1'b0};
    vt[2]  = '{halves(-3),      E_M15,    1'b0};
    vt[3]  = '{halves(81920),   16'h7FFF, 1'b1};
    vt[4]  = '{halves(65535),   16'h7FFF, 1'b1};
    vt[5]  = '{halves(-81920),  16'h8000, 1'b1};
    vt[6]  = '{halves(-65536),  16'h8000, 1'b0};
    vt[7]  = '{halves(65534),   16'h7FFF, 1'b0};
    vt[8]  = '{halves(-65537),  16'h8000, 1'b0};
    vt[9]  = '{halves(-65538),  16'h8000, 1'b1};
    vt[10] = '{{1'b0, {66{1'b1}}}, 16'h7FFF, 1'b1};
    vt[11] = '{{1'b1, {66{1'b0}}}, 16'h8000, 1'b1};
    vt[12] = '{halves(0),       16'h0000, 1'b0};
    vt[13] = '{halves(7),       16'h0004, 1'b0};

    RST = 1'b1; din = '0; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    #2;
    chk("reset_out_data", 64'(out_data), 64'h0);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_ovf", 64'(ovf_sticky), 64'h0);
    chk("reset_drop", 64'(drop_sticky), 64'h0);
    chk("reset_level", 64'(level), 64'h0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);

    // Sticky clear, and set winning over a coincident clear
    chk("clr_before", 64'(ovf_sticky), 64'(vt[13].exp_ovf));
    pulse_clr();
    din = halves(81920); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_set_wins", 64'(ovf_sticky), 64'h1);
    pulse_clr();
    chk("ovf_cleared", 64'(ovf_sticky), 64'h0);
    flush();

    // Latency and drop: six strobes into a stalled FIFO
    pulse_clr();
    for (int k = 1; k <= 6; k++) begin
      din = halves(2 * k); in_valid = 1'b1;
      tick();
      ov[k] = out_valid;
    end
    in_valid = 1'b0;
    chk("lat_valid_c2", 64'(ov[2]), 64'h0);
    chk("lat_valid_c3", 64'(ov[3]), 64'h1);
    repeat (4) tick();
    chk("drop_level", 64'(level), 64'd4);
    chk("drop_sticky", 64'(drop_sticky), 64'h1);
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      chk($sformatf("drain_%0d", j), 64'(out_data), 64'(j));
      tick();
    end
    chk("drain_valid_low", 64'(out_valid), 64'h0);
    chk("drain_level", 64'(level), 64'h0);
    out_ready = 1'b0;

    // Full FIFO with a pop coinciding with the incoming write
    pulse_clr();
    for (int k = 10; k <= 13; k++) begin
      din = halves(2 * k); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("full_level", 64'(level), 64'd4);
    din = halves(28); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fullpop_level", 64'(level), 64'd4);
    chk("fullpop_drop", 64'(drop_sticky), 64'h0);
    out_ready = 1'b1;
    for (int j = 11; j <= 14; j++) begin
      chk($sformatf("fullpop_drain_%0d", j), 64'(out_data), 64'(j));
      tick();
    end
    chk("fullpop_empty", 64'(out_valid), 64'h0);
    out_ready = 1'b0;

    // Asynchronous reset with 3 buffered and 2 in flight
    for (int k = 20; k <= 24; k++) begin
      din = halves(2 * k); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_level", 64'(level), 64'h0);
    chk("arst_data", 64'(out_data), 64'h0);
    @(posedge CLK); #3 RST = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      tick();
      if (out_valid) stale++;
    end
    chk("arst_no_stale", 64'(stale), 64'h0);
    out_ready = 1'b0;

    // Randomized scoreboard run; outstanding samples capped at DEPTH
    pulse_clr();
    any_sat = 1'b0;
    for (int c = 0; c < 800; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (q.size() > 0) chk("rand_data", 64'(out_data), 64'(q.pop_front()));
        else chk("rand_spurious_valid", 64'(out_valid), 64'h0);
      end
      in_valid = 1'b0;
      if (q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        d = rand_din();
        din = d; in_valid = 1'b1;
        q.push_back(model_q(d, s));
        any_sat |= s;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 30) begin
      if (out_valid) chk("rand_drain", 64'(out_data), 64'(q.pop_front()));
      tick();
      guard++;
    end
    chk("rand_all_delivered", 64'(q.size()), 64'h0);
    chk("rand_drop", 64'(drop_sticky), 64'h0);
    chk("rand_ovf", 64'(ovf_sticky), 64'(any_sat));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iir_out_quant.md
Name: iir_out_quant

Overview:
- Downstream output stage for the time-multiplexed SOS cascade. Consumes the full-precision cascade result once per sample, strobed by in_valid.
- Rounds the fractional part from WFI to WFQ bits and saturates the integer part from WII to WIQ bits. Flags any overflow with a sticky bit.
- Buffers results in a small FIFO with a valid/ready output handshake toward the DAC/packetiser side.

Parameters:
- WII, 23, integer bits of input sample
- WFI, 44, fractional bits of input sample
- WIQ, 5, integer bits of quantised output
- WFQ, 11, fractional bits of quantised output
- DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active-high
- din  in  WII+WFI  signed two's-complement cascade output
- in_valid  in  1  one-cycle strobe; din is valid this cycle
- out_data  out  WIQ+WFQ  signed quantised sample at FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready
- clr_flags  in  1  synchronous clear of sticky flags
- ovf_sticky  out  1  a saturation has occurred since the last clear
- drop_sticky  out  1  a sample was discarded because the FIFO was full
- level  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, asynchronous, all outputs: out_data=0, out_valid=0, ovf_sticky=0, drop_sticky=0, level=0.
  - Pipeline valid bits and FIFO pointers are cleared.
  - Reset mid-operation discards all in-flight and buffered samples.
- Constraints: WFI>WFQ and WII>=WIQ; elaborate-time error otherwise.
- Stage 1, round (registered on in_valid):
  - Add 2^(WFI-WFQ-1) to din, sign-extended by 1 bit to avoid wrap.
  - Truncate the low WFI-WFQ bits.
  - Result width WII+1+WFQ.
  - Default rounding is round-half-up (toward +inf on ties).
- Stage 2, saturate (registered):
  - If the rounded value > 2^(WIQ-1)-2^-WFQ, output the max code 0111..1.
  - If it is < -2^(WIQ-1), output the min code 1000..0.
  - Otherwise keep the low WIQ+WFQ bits.
  - Saturation sets ovf_sticky in the same cycle the stage-2 register loads.
- FIFO write:
  - Stage-2 valid writes the result into the FIFO at the end of stage 2.
  - Latency from in_valid to out_valid rising is 3 cycles on an empty FIFO (2 pipeline registers + FIFO register).
- FIFO read: pop when out_valid & out_ready. out_data is registered and updates on the cycle after the pop.
- Full with write pending:
  - If a pop occurs in the same cycle, the write proceeds and level stays unchanged.
  - Otherwise the sample is dropped, drop_sticky is set, and FIFO contents are untouched.
- Empty: out_valid=0 and out_data holds its last value. A pop attempt while empty is ignored.
- Simultaneous push and pop on a non-full, non-empty FIFO: level is unchanged.
- Pointers wrap modulo DEPTH. level is derived from wr_ptr-rd_ptr, using one extra bit for full/empty disambiguation.
- Sticky flags:
  - clr_flags clears ovf_sticky and drop_sticky.
  - If clr_flags coincides with a new overflow or drop event, the flag remains set (set wins).
- in_valid back-to-back on every cycle is supported: full throughput of 1 sample/cycle.

Optional Feature:
- Macro IIR_OUT_CONVERGENT_ROUND_EN.
- Defined: stage 1 uses round-half-to-even.
  - On an exact tie (discarded bits = 100..0), round up only if the retained LSB is 1; otherwise truncate.
  - Non-tie inputs behave identically to default.
- Undefined: round-half-up as described above. Latency and widths are the same in both builds.

Test Plan:
- Ties. din=+1.5 output LSB (3*2^(WFI-WFQ-1)) -> 0x0002 in both builds. din=+2.5 LSB -> 0x0003 default, 0x0002 with macro. din=-1.5 LSB -> 0xFFFF default, 0xFFFE with macro.
- Positive saturation and rounding carry. din=+20.0 -> 0x7FFF with ovf_sticky=1. din=15.99975 (rounds to 16.0) -> 0x7FFF with ovf_sticky set. clr_flags then clears ovf_sticky to 0.
- Negative saturation and boundary. din=-20.0 -> 0x8000 with ovf_sticky=1. din=-16.0 exactly -> 0x8000 with ovf_sticky unchanged.
- Latency and drop. out_ready=0, pulse in_valid on 6 consecutive cycles with din=1,2,..6 LSB. out_valid rises 3 cycles after the first strobe and level reaches 4. drop_sticky=1 with samples 5 and 6 lost. Raising out_ready then yields 1,2,3,4 in order, one per cycle, and out_valid falls.
- Full with simultaneous pop. FIFO full and out_ready=1 while a 5th sample reaches the FIFO -> sample accepted, level stays 4, drop_sticky stays 0.
- Reset mid-operation. Assert RST asynchronously with 3 entries buffered and 2 in flight -> out_valid=0 and level=0 immediately. After release, no stale sample ever appears.
